// File: rtl/par_to_ser_mc_pkg.sv
// Shared constants and helpers for the multi-channel DDR serializer.
//   ratio_of  : clocks per word (bit pairs per word) for a given word width
//   par_w_ok  : word-width legality check used at elaboration
//   DEF_*     : default TMDS control symbols for idle and link training
package par_to_ser_mc_pkg;

  localparam logic [9:0] DEF_IDLE_WORD  = 10'b1101010100;
  localparam logic [9:0] DEF_TRAIN_WORD = 10'b0000011111;

  function automatic int ratio_of(input int par_w);
    return par_w / 2;
  endfunction

  function automatic bit par_w_ok(input int par_w);
    return ((par_w % 2) == 0) && (par_w >= 4);
  endfunction

endpackage

// File: rtl/par_to_ser_mc_if.sv
// Parallel word handshake bundle shared by all channels.
//   in_data  : CH words, channel c at [c*PAR_W +: PAR_W], bit 0 sent first
//   in_valid : in_data valid
//   in_ready : serializer can accept a word this cycle
interface par_to_ser_mc_if #(
  parameter int CH    = 3,
  parameter int PAR_W = 10
) ();
  logic [CH*PAR_W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/par_to_ser_mc_lane_shift.sv
// One channel's rise/fall split shifter.
//   clk, rst_n : serial-pair clock, synchronous active-low reset
//   load       : load slot; capture word, present bit pair 0 next cycle
//   word       : word to serialize (bit 0 first)
//   rise, fall : registered bit for the DDR rising / falling half
module par_to_ser_mc_lane_shift
  import par_to_ser_mc_pkg::*;
#(
  parameter int PAR_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PAR_W-1:0] word,
  output logic             rise,
  output logic             fall
);

  localparam int RATIO = ratio_of(PAR_W);

  logic [RATIO-1:0] evens, odds;
  logic [RATIO-2:0] rise_sr, fall_sr;

  always_comb begin
    evens = '0;
    odds  = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      evens[k] = word[2*k];
      odds[k]  = word[2*k+1];
    end
  end

  // Pair 0 goes straight to the output register on load; the shifters
  // hold only the remaining RATIO-1 pairs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise    <= 1'b0;
      fall    <= 1'b0;
      rise_sr <= '0;
      fall_sr <= '0;
    end else if (load) begin
      rise    <= evens[0];
      fall    <= odds[0];
      rise_sr <= evens[RATIO-1:1];
      fall_sr <= odds[RATIO-1:1];
    end else begin
      rise    <= rise_sr[0];
      fall    <= fall_sr[0];
      rise_sr <= rise_sr >> 1;
      fall_sr <= fall_sr >> 1;
    end
  end

endmodule

// File: rtl/par_to_ser_mc.sv
// Multi-channel parallel-to-serial DDR splitter.
//   clk_5x, rst_n : serial-pair clock, synchronous active-low reset
//   bus (slave)   : in_data / in_valid / in_ready word handshake
//   train_en      : send TRAIN_WORD at load slots instead of buffered data
//   ser_rise/fall : per-channel DDR rising / falling half bits
//   word_start    : ser_* carry bit pair 0 of a new word
//   underflow     : IDLE_WORD substituted after first transfer
//   uf_count      : saturating underflow count
module par_to_ser_mc
  import par_to_ser_mc_pkg::*;
#(
  parameter int               PAR_W      = 10,
  parameter int               CH         = 3,
  parameter logic [PAR_W-1:0] IDLE_WORD  = PAR_W'(DEF_IDLE_WORD),
  parameter logic [PAR_W-1:0] TRAIN_WORD = PAR_W'(DEF_TRAIN_WORD),
  parameter int               UF_CNT_W   = 16
) (
  input  logic                clk_5x,
  input  logic                rst_n,
  par_to_ser_mc_if.slave      bus,
  input  logic                train_en,
  output logic [CH-1:0]       ser_rise,
  output logic [CH-1:0]       ser_fall,
  output logic                word_start,
  output logic                underflow,
  output logic [UF_CNT_W-1:0] uf_count
);

  localparam int RATIO = ratio_of(PAR_W);
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (!par_w_ok(PAR_W)) begin : g_bad_par_w
    $error("PAR_W must be even and >= 4");
  end

  logic [CW-1:0]       cnt;
  logic                load_slot, xfer, hold_valid, armed, idle_load;
  logic [CH*PAR_W-1:0] hold, load_word;

  assign load_slot    = (cnt == CW'(RATIO - 1));
  assign bus.in_ready = rst_n && (!hold_valid || (load_slot && !train_en));
  assign xfer         = bus.in_valid && bus.in_ready;
  assign idle_load    = load_slot && !train_en && !hold_valid;

  always_comb begin
    load_word = {CH{IDLE_WORD}};
    if (train_en)        load_word = {CH{TRAIN_WORD}};
    else if (hold_valid) load_word = hold;
  end

  always_ff @(posedge clk_5x) begin
    if (!rst_n)         cnt <= '0;
    else if (load_slot) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  // A transfer at the load slot refills the hold as it drains, so it wins
  // over the clear.
  always_ff @(posedge clk_5x) begin
    if (!rst_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      armed      <= 1'b0;
    end else if (xfer) begin
      hold       <= bus.in_data;
      hold_valid <= 1'b1;
      armed      <= 1'b1;
    end else if (load_slot && !train_en) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_5x) begin
    if (!rst_n) begin
      word_start <= 1'b0;
      underflow  <= 1'b0;
      uf_count   <= '0;
    end else begin
      word_start <= load_slot;
      underflow  <= idle_load && armed;
      if (idle_load && armed && (uf_count != '1))
        uf_count <= uf_count + 1'b1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    par_to_ser_mc_lane_shift #(
      .PAR_W (PAR_W)
    ) u_lane (
      .clk   (clk_5x),
      .rst_n (rst_n),
      .load  (load_slot),
      .word  (load_word[c*PAR_W +: PAR_W]),
      .rise  (ser_rise[c]),
      .fall  (ser_fall[c])
    );
  end

endmodule

// File: tb/tb_par_to_ser_mc.sv
// Self-checking bench for par_to_ser_mc: directed phases followed by random
// traffic, compared each cycle against a queue-of-bit-pairs reference model.
module tb_par_to_ser_mc;

  localparam int PAR_W = 10;
  localparam int CH    = 3;
  localparam int RATIO = PAR_W / 2;
  localparam int UFW   = 4;
  localparam logic [PAR_W-1:0] IDLE  = 10'b1101010100;
  localparam logic [PAR_W-1:0] TRAIN = 10'b0000011111;

  typedef struct {
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    logic          s;
  } pair_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                train_en;
  logic [CH-1:0]       ser_rise, ser_fall;
  logic                word_start, underflow;
  logic [UFW-1:0]      uf_count;

  par_to_ser_mc_if #(.CH(CH), .PAR_W(PAR_W)) bus ();

  par_to_ser_mc #(
    .PAR_W    (PAR_W),
    .CH       (CH),
    .UF_CNT_W (UFW)
  ) dut (
    .clk_5x     (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .train_en   (train_en),
    .ser_rise   (ser_rise),
    .ser_fall   (ser_fall),
    .word_start (word_start),
    .underflow  (underflow),
    .uf_count   (uf_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int                  m_cnt = 0;
  logic                m_hv = 1'b0;
  logic                m_armed = 1'b0;
  logic [CH*PAR_W-1:0] m_hold = '0;
  logic                m_uf = 1'b0;
  int                  m_ufc = 0;
  logic                m_xfer = 1'b0;
  pair_t               m_out = '{r: '0, f: '0, s: 1'b0};
  pair_t               q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [CH*PAR_W-1:0] w);
    pair_t p;
    for (int k = 0; k < RATIO; k++) begin
      for (int c = 0; c < CH; c++) begin
        p.r[c] = w[c*PAR_W + 2*k];
        p.f[c] = w[c*PAR_W + 2*k + 1];
      end
      p.s = (k == 0);
      q.push_back(p);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic t,
                            input logic [CH*PAR_W-1:0] d, input logic rdy);
    logic ld, uf_n;
    if (!r) begin
      m_cnt = 0; m_hv = 1'b0; m_armed = 1'b0; m_hold = '0;
      m_uf = 1'b0; m_ufc = 0; m_xfer = 1'b0;
      q.delete();
      m_out = '{r: '0, f: '0, s: 1'b0};
      return;
    end
    ld     = (m_cnt == RATIO - 1);
    m_xfer = v && rdy;
    uf_n   = 1'b0;
    if (ld) begin
      if (t)         push_word({CH{TRAIN}});
      else if (m_hv) push_word(m_hold);
      else begin
        push_word({CH{IDLE}});
        uf_n = m_armed;
      end
    end
    if (m_xfer) begin
      m_hold = d; m_hv = 1'b1; m_armed = 1'b1;
    end else if (ld && !t) begin
      m_hv = 1'b0;
    end
    m_uf = uf_n;
    if (uf_n && m_ufc < (1 << UFW) - 1) m_ufc++;
    m_cnt = (m_cnt + 1) % RATIO;
    if (q.size() > 0) m_out = q.pop_front();
    else              m_out = '{r: '0, f: '0, s: 1'b0};
  endtask

  task automatic cycle(input logic r, input logic v, input logic t,
                       input logic [CH*PAR_W-1:0] d);
    logic rdy;
    @(negedge clk);
    chk("ser_rise",   64'(ser_rise),   64'(m_out.r));
    chk("ser_fall",   64'(ser_fall),   64'(m_out.f));
    chk("word_start", 64'(word_start), 64'(m_out.s));
    chk("underflow",  64'(underflow),  64'(m_uf));
    chk("uf_count",   64'(uf_count),   64'(m_ufc));
    rst_n        = r;
    bus.in_valid = v;
    bus.in_data  = d;
    train_en     = t;
    #1;
    rdy = r && (!m_hv || ((m_cnt == RATIO - 1) && !t));
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    model_step(r, v, t, d, rdy);
  endtask

  initial begin
    logic [PAR_W-1:0]    w;
    logic [CH*PAR_W-1:0] d;
    int                  got;

    rst_n = 1'b0; train_en = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    @(posedge clk);
    cycle(0, 0, 0, '0);

    // idle after reset: IDLE pattern, silent
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, '0);

    // single word accepted at cnt==0
    cycle(0, 0, 0, '0);
    cycle(1, 1, 0, {10'h3E0, 10'h155, 10'h2AA});
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, '0);

    // continuous incrementing words
    w = 10'h001;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 0, {w + 10'd2, w + 10'd1, w});
      if (m_xfer) w = w + 10'd3;
    end

    // three words then starve
    cycle(0, 0, 0, '0);
    got = 0;
    for (int i = 0; i < 30 && got < 3; i++) begin
      cycle(1, 1, 0, {w + 10'd2, w + 10'd1, w});
      if (m_xfer) begin w = w + 10'd3; got++; end
    end
    chk("three_words_taken", 64'(got), 64'd3);
    for (int i = 0; i < 25; i++) cycle(1, 0, 0, '0);

    // training with hold full
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0, {w + 10'd2, w + 10'd1, w});
      if (m_xfer) w = w + 10'd3;
    end
    for (int i = 0; i < 2 * RATIO; i++) cycle(1, 1, 1, {w + 10'd2, w + 10'd1, w});
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 0, {w + 10'd2, w + 10'd1, w});
      if (m_xfer) w = w + 10'd3;
    end

    // reset mid-word at cnt==2
    for (int i = 0; i < RATIO && m_cnt != 2; i++) cycle(1, 0, 0, '0);
    chk("reached_cnt2", 64'(m_cnt), 64'd2);
    cycle(0, 1, 0, '1);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, '0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      d = (CH*PAR_W)'({$urandom(), $urandom()});
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) == 0), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
